uart_imem_loader: RTL

//   UART boot loader upstream of the rv32i_soc instruction memory. Receives a framed program image on the

---
 rtl/uart_imem_loader.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_imem_loader
// Purpose  : UART (8N1) boot loader for the rv32i_soc instruction memory.
//            Waits for SYNC_BYTE, reads a 16-bit little-endian word count,
//            then assembles little-endian 32-bit words and writes them to
//            imem via a request/acknowledge port. The core is held in
//            reset until a complete image has been written.
// Ports    : clk, reset (sync, active-high)
//            i_uart_rx    - asynchronous serial input, idle high
//            o_imem_we    - write request, held until i_imem_ack
//            o_imem_addr  - word address of current write
//            o_imem_wdata - word being written
//            i_imem_ack   - single-cycle write-accepted pulse
//            o_core_rst   - core reset, released after a successful load
//            o_busy       - load in progress (SYNC_BYTE seen, not finished)
//            o_done       - sticky, image loaded
//            o_err        - sticky framing/overrun/length error
// Revision : 1.0 - initial release
// ============================================================================
module uart_imem_loader #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         ADDR_W       = 12,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_uart_rx,
    output logic                   o_imem_we,
    output logic [ADDR_W-1:0]      o_imem_addr,
    output logic [31:0]            o_imem_wdata,
    input  wire logic              i_imem_ack,
    output logic                   o_core_rst,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err
);

    localparam int               c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      c_MAX_WORDS = 17'(2 ** ADDR_W);

    localparam logic [1:0] c_RX_IDLE  = 2'd0;
    localparam logic [1:0] c_RX_START = 2'd1;
    localparam logic [1:0] c_RX_DATA  = 2'd2;
    localparam logic [1:0] c_RX_STOP  = 2'd3;

    localparam logic [2:0] c_L_SYNC  = 3'd0;
    localparam logic [2:0] c_L_LEN0  = 3'd1;
    localparam logic [2:0] c_L_LEN1  = 3'd2;
    localparam logic [2:0] c_L_DATA  = 3'd3;
    localparam logic [2:0] c_L_WRITE = 3'd4;
    localparam logic [2:0] c_L_DONE  = 3'd5;

    // ---------------- RX synchroniser ----------------
    logic r_rx_meta, r_rx_sync;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_uart_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ---------------- RX FSM ----------------
    logic [1:0]         r_rx_state, w_rx_state_nxt;
    logic [c_CNT_W-1:0] r_rx_cnt, w_cnt_last;
    logic [2:0]         r_rx_bit;
    logic [7:0]         r_rx_shift;
    logic               w_rx_tick, w_byte_valid, w_frame_err;

    always_ff @(posedge clk) begin
        if (reset) r_rx_state <= c_RX_IDLE;
        else       r_rx_state <= w_rx_state_nxt;
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            c_RX_IDLE:  if (!r_rx_sync) w_rx_state_nxt = c_RX_START;
            // Line must still be low at mid start bit, else it was a glitch.
            c_RX_START: if (w_rx_tick) w_rx_state_nxt = r_rx_sync ? c_RX_IDLE : c_RX_DATA;
            c_RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_state_nxt = c_RX_STOP;
            c_RX_STOP:  if (w_rx_tick) w_rx_state_nxt = c_RX_IDLE;
            default:    w_rx_state_nxt = c_RX_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_last   = (r_rx_state == c_RX_START) ? c_HALF_LAST : c_BIT_LAST;
        w_rx_tick    = (r_rx_cnt == w_cnt_last);
        w_byte_valid = (r_rx_state == c_RX_STOP) && w_rx_tick && r_rx_sync;
        w_frame_err  = (r_rx_state == c_RX_STOP) && w_rx_tick && !r_rx_sync;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            if (r_rx_state == c_RX_IDLE || w_rx_tick) r_rx_cnt <= '0;
            else                                      r_rx_cnt <= r_rx_cnt + c_CNT_W'(1);
            if (r_rx_state == c_RX_START) begin
                r_rx_bit <= 3'd0;
            end else if (r_rx_state == c_RX_DATA && w_rx_tick) begin
                r_rx_bit   <= r_rx_bit + 3'd1;
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            end
        end
    end

    // ---------------- Byte buffer ----------------
    logic       r_buf_full;
    logic [7:0] r_buf_data;
    logic       w_consume;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_full <= 1'b0;
            r_buf_data <= 8'h00;
        end else if (w_byte_valid) begin
            r_buf_full <= 1'b1;
            r_buf_data <= r_rx_shift;
        end else if (w_consume) begin
            r_buf_full <= 1'b0;
        end
    end

    // ---------------- Loader FSM ----------------
    logic [2:0]        r_ld_state, w_ld_state_nxt;
    logic [15:0]       r_remaining;
    logic [1:0]        r_byte_idx;
    logic              r_we, r_core_rst, r_busy, r_done, r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              w_overrun, w_abort, w_len_err, w_ack_hit, w_is_sync;
    logic [15:0]       w_len;

    always_ff @(posedge clk) begin
        if (reset) r_ld_state <= c_L_SYNC;
        else       r_ld_state <= w_ld_state_nxt;
    end

    always_comb begin
        w_ld_state_nxt = r_ld_state;
        if (w_abort) begin
            w_ld_state_nxt = c_L_SYNC;
        end else begin
            case (r_ld_state)
                c_L_SYNC:  if (w_consume && w_is_sync) w_ld_state_nxt = c_L_LEN0;
                c_L_LEN0:  if (w_consume) w_ld_state_nxt = c_L_LEN1;
                c_L_LEN1:
                    if (w_consume) begin
                        if (w_len == 16'd0) w_ld_state_nxt = c_L_DONE;
                        else if (w_len_err) w_ld_state_nxt = c_L_SYNC;
                        else                w_ld_state_nxt = c_L_DATA;
                    end
                c_L_DATA:  if (w_consume && r_byte_idx == 2'd3) w_ld_state_nxt = c_L_WRITE;
                c_L_WRITE:
                    if (w_ack_hit) w_ld_state_nxt = (r_remaining == 16'd1) ? c_L_DONE : c_L_DATA;
                c_L_DONE:  w_ld_state_nxt = c_L_DONE;
                default:   w_ld_state_nxt = c_L_SYNC;
            endcase
        end
    end

    always_comb begin
        // The buffer is drained in every state except while a write is pending;
        // in L_DONE bytes are simply dropped.
        w_consume = r_buf_full && (r_ld_state != c_L_WRITE);
        w_overrun = w_byte_valid && r_buf_full && !w_consume;
        w_abort   = (w_frame_err || w_overrun) &&
                    (r_ld_state != c_L_SYNC) && (r_ld_state != c_L_DONE);
        w_is_sync = (r_buf_data == SYNC_BYTE);
        w_len     = {r_buf_data, r_remaining[7:0]};
        w_len_err = (r_ld_state == c_L_LEN1) && w_consume && ({1'b0, w_len} > c_MAX_WORDS);
        w_ack_hit = (r_ld_state == c_L_WRITE) && i_imem_ack;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'h0;
            r_core_rst  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_remaining <= 16'd0;
            r_byte_idx  <= 2'd0;
        end else if (w_abort) begin
            r_err  <= 1'b1;
            r_busy <= 1'b0;
            r_we   <= 1'b0;
            r_addr <= '0;
        end else begin
            case (r_ld_state)
                c_L_SYNC:
                    if (w_consume && w_is_sync) begin
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        r_addr <= '0;
                    end
                c_L_LEN0:
                    if (w_consume) r_remaining <= {8'h00, r_buf_data};
                c_L_LEN1:
                    if (w_consume) begin
                        r_remaining <= w_len;
                        r_byte_idx  <= 2'd0;
                        if (w_len_err) begin
                            r_err  <= 1'b1;
                            r_busy <= 1'b0;
                        end
                    end
                c_L_DATA:
                    if (w_consume) begin
                        // Shift in at the top so the first byte ends up in [7:0].
                        r_wdata    <= {r_buf_data, r_wdata[31:8]};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) r_we <= 1'b1;
                    end
                c_L_WRITE:
                    if (w_ack_hit) begin
                        r_we        <= 1'b0;
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_remaining <= r_remaining - 16'd1;
                    end
                default: ;
            endcase
            if (w_ld_state_nxt == c_L_DONE && r_ld_state != c_L_DONE) begin
                r_done     <= 1'b1;
                r_busy     <= 1'b0;
                r_core_rst <= 1'b0;
            end
        end
    end

    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_core_rst   = r_core_rst;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule
`default_nettype wire
